qam64_demod: RTL and testbench
==============================

Name: qam64_demod

Overview:
- Hard-decision 64-QAM demapper for the OFDM RX path. It is the inverse of the TX QAM64 mapper.
- Accepts complex samples {Im,Re} of 16-bit two's complement each (equalizer output). Emits 6-bit Gray-coded symbols {Re bits[5:3], Im bits[2:0]}.
- Uses the same Wishbone-style streaming handshake as the rest of the chain.
- Two-stage registered pipeline with full backpressure stall.

Parameters:
- TH1, 16'h2780, |x| threshold between levels 1 and 3 (10112).
- TH2, 16'h4F00, |x| threshold between levels 3 and 5 (20224).
- TH3, 16'h7680, |x| threshold between levels 5 and 7 (30336).
- CLIP_TH, 16'h7F00, |x| clip-detect threshold (used only with the optional feature).

Ports:
- CLK_I, in, 1, clock.
- RST_I, in, 1, reset.
- DAT_I, in, 32, [31:16]=Im, [15:0]=Re, signed.
- CYC_I, in, 1, upstream cycle.
- WE_I, in, 1, upstream write.
- STB_I, in, 1, upstream strobe.
- ACK_O, out, 1, sample accepted.
- DAT_O, out, 6, {Re[2:0], Im[2:0]} symbol.
- CYC_O, out, 1, downstream cycle.
- STB_O, out, 1, downstream strobe.
- WE_O, out, 1, equals STB_O.
- ACK_I, in, 1, downstream accept.

Behaviour:
- Clock and reset: one clock, CLK_I. RST_I is synchronous and active-high.
- Reset values: ACK_O follows the combinational rule (it is 0 unless input is valid); DAT_O=0, STB_O=0, CYC_O=0, WE_O=0. Internal stage-1 data is 0 and stage-1 valid is 0.
- Handshake definitions:
  - out_halt = STB_O & ~ACK_I
  - ena = CYC_I & STB_I & WE_I
  - ACK_O = ena & ~out_halt (combinational)
- Stage 1:
  - If ACK_O: capture DAT_I and set valid=1.
  - Else if ~out_halt: valid=0.
  - Else: hold.
- Stage 2 (output):
  - If ~out_halt: STB_O <= stage-1 valid. DAT_O <= slice(stage-1 data) when valid, otherwise hold.
  - If out_halt: hold DAT_O and STB_O.
- Latency: a sample with ACK_O=1 in cycle n appears with STB_O=1 in cycle n+2, absent stalls.
- Throughput: 1 sample/cycle sustained when ACK_I=1. No sample is dropped or duplicated under any ACK_I pattern.
- CYC_O: CYC_I delayed two cycles, OR'd with (stage-1 valid | STB_O), so the cycle never drops while data is in flight.
- Slicer, per axis (Re, Im independently):
  - sign s = x[15]. |x| is computed in 17 bits, so 16'h8000 gives 32768.
  - |x| < TH1 → level 1; < TH2 → level 3; < TH3 → level 5; else level 7. A value exactly on a threshold goes to the outer level.
  - Bits = {s, m}, with m: level1=01, level3=00, level5=10, level7=11. Zero is positive.
  - Resulting codes: +7=011, +5=010, +3=000, +1=001, -1=101, -3=100, -5=110, -7=111.
- Reset mid-operation: both stages are invalidated the next cycle. Any in-flight samples are discarded, and ACK_O re-evaluates immediately.
- Simultaneous ACK_I=1 with a new accept: output advances and stage 1 refills in the same cycle.

Optional Feature:
- Macro: QAM64_DEMOD_CLIP_EN.
- Defined:
  - Adds output CLIP_O (1 bit) and output CLIP_CNT_O (16 bits).
  - CLIP_O is registered alongside DAT_O and is 1 when |Re|>=CLIP_TH or |Im|>=CLIP_TH. It holds under stall.
  - CLIP_CNT_O increments, saturating at 16'hFFFF, on each output transfer (STB_O & ACK_I) whose CLIP_O=1.
  - Reset clears both.
- Undefined: neither port exists, and no clip logic is built.

Test Plan:
- Ideal points: DAT_I=32'h13C0_8001 (Im=+1, Re=-7) → DAT_O=6'b111_001. DAT_I=32'h9D3F_62C1 → 6'b010_110. Sweep all 64 TX constellation points and check exact inversion.
- Thresholds, Re with Im=0:
  - 16'h277F → 001
  - 16'h2780 → 000
  - 16'h0000 → 001
  - 16'hD880 → 100
  - 16'h8000 → 111
  - 16'h7680 → 011
- Backpressure: stream 8 distinct symbols with ACK_I low for 3 cycles mid-stream → ACK_O low during halt, DAT_O/STB_O stable, all 8 delivered in order with no duplicates.
- Bubble/latency: single STB_I pulse at cycle 10 → STB_O high only in cycle 12, CYC_O high across it.
- Reset mid-stream with STB_O=1 and stage 1 full → next cycle STB_O=0, DAT_O=0, CYC_O=0. First post-reset sample appears at latency 2.
- QAM64_DEMOD_CLIP_EN: send 3 samples with Re=16'h7F00 and 2 with Re=16'h1000, all ACK_I=1 → CLIP_O pattern 1,1,1,0,0 and CLIP_CNT_O=3.

Source files
------------

// File: rtl/qam64_demod.sv
// qam64_demod: hard-decision 64-QAM demapper with a two-stage stallable pipeline.
// Defining QAM64_DEMOD_CLIP_EN adds clip detection (CLIP_O) and a saturating clip counter (CLIP_CNT_O).
module qam64_demod #(
    parameter logic [15:0] TH1     = 16'h2780,
    parameter logic [15:0] TH2     = 16'h4F00,
    parameter logic [15:0] TH3     = 16'h7680
`ifdef QAM64_DEMOD_CLIP_EN
    ,
    parameter logic [15:0] CLIP_TH = 16'h7F00
`endif
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        CYC_I,
    input  logic        WE_I,
    input  logic        STB_I,
    output logic        ACK_O,
    output logic [5:0]  DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I
`ifdef QAM64_DEMOD_CLIP_EN
    ,
    output logic        CLIP_O,
    output logic [15:0] CLIP_CNT_O
`endif
);

    // Magnitude in 17 bits so that -32768 stays representable.
    function automatic logic [16:0] abs17(input logic [15:0] x);
        logic [16:0] ext_s;
        ext_s = {x[15], x};
        if (x[15]) begin
            abs17 = 17'd0 - ext_s;
        end else begin
            abs17 = ext_s;
        end
    endfunction

    // Gray slice of one axis: outer level wins on an exact threshold hit.
    function automatic logic [2:0] slice_axis(input logic [15:0] x);
        logic [16:0] mag_s;
        logic [1:0]  m_s;
        mag_s = abs17(x);
        if (mag_s < {1'b0, TH1}) begin
            m_s = 2'b01;
        end else if (mag_s < {1'b0, TH2}) begin
            m_s = 2'b00;
        end else if (mag_s < {1'b0, TH3}) begin
            m_s = 2'b10;
        end else begin
            m_s = 2'b11;
        end
        slice_axis = {x[15], m_s};
    endfunction

    logic        out_halt_s;
    logic        ena_s;
    logic [31:0] s1_data_r;
    logic        s1_valid_r;
    logic [5:0]  sym_s;
    logic        cyc_d1_r;
    logic        cyc_d2_r;

    assign out_halt_s = STB_O & ~ACK_I;
    assign ena_s      = CYC_I & STB_I & WE_I;
    assign ACK_O      = ena_s & ~out_halt_s;
    assign WE_O       = STB_O;
    assign CYC_O      = cyc_d2_r | s1_valid_r | STB_O;

    // Symbol decision for the sample currently held in stage 1.
    always_comb begin
        sym_s = 6'h00;
        sym_s = {slice_axis(s1_data_r[15:0]), slice_axis(s1_data_r[31:16])};
    end

    // Stage 1: capture on accept, drain when the output moves, hold under stall.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            s1_data_r  <= 32'h0000_0000;
            s1_valid_r <= 1'b0;
        end else if (ACK_O) begin
            s1_data_r  <= DAT_I;
            s1_valid_r <= 1'b1;
        end else if (!out_halt_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: registered output symbol and strobe, frozen while downstream stalls.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            DAT_O <= 6'h00;
            STB_O <= 1'b0;
        end else if (!out_halt_s) begin
            STB_O <= s1_valid_r;
            if (s1_valid_r) begin
                DAT_O <= sym_s;
            end
        end
    end

    // Two-cycle delay of the upstream cycle flag.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cyc_d1_r <= 1'b0;
            cyc_d2_r <= 1'b0;
        end else begin
            cyc_d1_r <= CYC_I;
            cyc_d2_r <= cyc_d1_r;
        end
    end

`ifdef QAM64_DEMOD_CLIP_EN
    logic clip_s;

    // Clip flag of the stage-1 sample, on either axis.
    always_comb begin
        clip_s = 1'b0;
        clip_s = (abs17(s1_data_r[15:0])  >= {1'b0, CLIP_TH}) |
                 (abs17(s1_data_r[31:16]) >= {1'b0, CLIP_TH});
    end

    // Clip flag travels with DAT_O and holds with it.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            CLIP_O <= 1'b0;
        end else if (!out_halt_s && s1_valid_r) begin
            CLIP_O <= clip_s;
        end
    end

    // Saturating count of clipped symbols actually transferred downstream.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            CLIP_CNT_O <= 16'h0000;
        end else if (STB_O && ACK_I && CLIP_O && (CLIP_CNT_O != 16'hFFFF)) begin
            CLIP_CNT_O <= CLIP_CNT_O + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_qam64_demod.sv
// Self-checking bench for qam64_demod: queue-based reference model plus directed latency,
// threshold, backpressure and reset cases; clip checks are built when QAM64_DEMOD_CLIP_EN is defined.
module tb_qam64_demod;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic [31:0] DAT_I = 32'h0;
    logic        CYC_I = 1'b0;
    logic        WE_I  = 1'b0;
    logic        STB_I = 1'b0;
    logic        ACK_I = 1'b0;
    logic        ACK_O;
    logic [5:0]  DAT_O;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
`ifdef QAM64_DEMOD_CLIP_EN
    logic        CLIP_O;
    logic [15:0] CLIP_CNT_O;
    int          clip_cnt_exp = 0;
`endif

    int total = 0;
    int bad   = 0;

    qam64_demod dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .WE_I(WE_I),
        .STB_I(STB_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
        .WE_O(WE_O), .ACK_I(ACK_I)
`ifdef QAM64_DEMOD_CLIP_EN
        , .CLIP_O(CLIP_O), .CLIP_CNT_O(CLIP_CNT_O)
`endif
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decision: plain integer magnitude against the level boundaries.
    function automatic logic [2:0] ref_slice(input logic [15:0] x);
        int v, a;
        logic [1:0] m;
        v = $signed(x);
        a = (v < 0) ? -v : v;
        if (a < 10112)      m = 2'b01;
        else if (a < 20224) m = 2'b00;
        else if (a < 30336) m = 2'b10;
        else                m = 2'b11;
        return {v < 0, m};
    endfunction

    function automatic logic ref_clip(input logic [31:0] d);
        int re, im;
        re = $signed(d[15:0]);
        im = $signed(d[31:16]);
        if (re < 0) re = -re;
        if (im < 0) im = -im;
        return (re >= 32512) || (im >= 32512);
    endfunction

    // TX mapper axis value for a 3-bit Gray code (level 7 saturates to full scale).
    function automatic logic [15:0] tx_axis(input logic [2:0] c);
        int amp, v;
        logic [15:0] r;
        case (c[1:0])
            2'b01:   amp = 5056;
            2'b00:   amp = 15168;
            2'b10:   amp = 25281;
            default: amp = 32767;
        endcase
        v = c[2] ? -amp : amp;
        r = 16'(v);
        return r;
    endfunction

    function automatic logic [31:0] tx_point(input logic [5:0] k);
        return {tx_axis(k[2:0]), tx_axis(k[5:3])};
    endfunction

    function automatic logic [15:0] rand_axis();
        int e [8] = '{10112, 20224, 30336, 0, 32767, 32768, 5056, 25281};
        int v;
        logic [15:0] r;
        if ($urandom_range(0, 1) == 0) begin
            r = 16'($urandom);
        end else begin
            v = e[$urandom_range(0, 7)] + $urandom_range(0, 2) - 1;
            if ($urandom_range(0, 1) == 1) v = -v;
            r = 16'(v);
        end
        return r;
    endfunction

    // Reference model state: accepted samples not yet delivered, and the CYC_I history.
    logic [31:0] mq [$];
    int          n_del = 0;
    logic        h1 = 1'b0, h2 = 1'b0;
    logic        prev_rst = 1'b1, prev_halt = 1'b0;
    logic [5:0]  prev_dat = 6'h00;
    logic [31:0] d;
    logic        exp_clip;

    // Compare process: every cycle, on the falling edge.
    initial begin
        forever begin
            @(negedge CLK_I);
            chk("ack_o", {31'h0, ACK_O}, {31'h0, CYC_I & STB_I & WE_I & ~(STB_O & ~ACK_I)});
            chk("we_o", {31'h0, WE_O}, {31'h0, STB_O});
            chk("cyc_o", {31'h0, CYC_O}, {31'h0, h2 | (mq.size() != 0)});
            if (!prev_rst && prev_halt) begin
                chk("stall_stb", {31'h0, STB_O}, 32'h1);
                chk("stall_dat", {26'h0, DAT_O}, {26'h0, prev_dat});
            end
`ifdef QAM64_DEMOD_CLIP_EN
            chk("clip_cnt", {16'h0, CLIP_CNT_O}, 32'(clip_cnt_exp));
`endif
            if (RST_I) begin
                mq.delete();
                h1 = 1'b0;
                h2 = 1'b0;
`ifdef QAM64_DEMOD_CLIP_EN
                clip_cnt_exp = 0;
`endif
            end else begin
                if (STB_O && ACK_I) begin
                    if (mq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_out actual=%h expected=none at %0t", DAT_O, $time);
                    end else begin
                        d = mq.pop_front();
                        n_del++;
                        chk("dat_o", {26'h0, DAT_O}, {26'h0, ref_slice(d[15:0]), ref_slice(d[31:16])});
                        exp_clip = ref_clip(d);
`ifdef QAM64_DEMOD_CLIP_EN
                        chk("clip_o", {31'h0, CLIP_O}, {31'h0, exp_clip});
                        if (exp_clip && clip_cnt_exp < 65535) clip_cnt_exp++;
`endif
                    end
                end
                if (ACK_O) mq.push_back(DAT_I);
                h2 = h1;
                h1 = CYC_I;
            end
            prev_rst  = RST_I;
            prev_halt = STB_O & ~ACK_I;
            prev_dat  = DAT_O;
        end
    end

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic drain();
        STB_I = 1'b0;
        ACK_I = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (mq.size() == 0 && !STB_O) break;
        end
        chk("drain_empty", 32'(mq.size()), 32'h0);
    endtask

    // One isolated sample: STB_O must rise exactly two cycles after the accept.
    task automatic single_check(input string name, input logic [31:0] dat, input logic [5:0] exp);
        tick();
        CYC_I = 1'b1; WE_I = 1'b1; STB_I = 1'b1; ACK_I = 1'b1; DAT_I = dat;
        #1 chk({name, "_ack"}, {31'h0, ACK_O}, 32'h1);
        tick();
        STB_I = 1'b0;
        chk({name, "_lat1"}, {31'h0, STB_O}, 32'h0);
        tick();
        chk({name, "_stb"}, {31'h0, STB_O}, 32'h1);
        chk({name, "_dat"}, {26'h0, DAT_O}, {26'h0, exp});
        chk({name, "_cyc"}, {31'h0, CYC_O}, 32'h1);
        tick();
        chk({name, "_lat3"}, {31'h0, STB_O}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] thr_v [6] = '{16'h277F, 16'h2780, 16'h0000, 16'hD880, 16'h8000, 16'h7680};
    logic [2:0]  thr_c [6] = '{3'b001, 3'b000, 3'b001, 3'b100, 3'b111, 3'b011};
    logic [5:0]  bp_sym [8];
    logic [31:0] pt;
    int          k, guard, sent, d0;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_dat", {26'h0, DAT_O}, 32'h0);
        chk("rst_stb", {31'h0, STB_O}, 32'h0);
        chk("rst_cyc", {31'h0, CYC_O}, 32'h0);
        chk("rst_we",  {31'h0, WE_O},  32'h0);
        chk("rst_ack_idle", {31'h0, ACK_O}, 32'h0);
        CYC_I = 1'b1; WE_I = 1'b1; STB_I = 1'b1; DAT_I = 32'h1234_5678;
        #1 chk("rst_ack_valid", {31'h0, ACK_O}, 32'h1);
        tick();
        RST_I = 1'b0; STB_I = 1'b0;
        tick();
        chk("rst_discard_a", {31'h0, STB_O}, 32'h0);
        tick();
        chk("rst_discard_b", {31'h0, STB_O}, 32'h0);

        // Ideal points and slicer thresholds (Im = 0 decides to +1 = 001)
        single_check("ideal0", 32'h13C0_8001, 6'b111_001);
        single_check("ideal1", 32'h9D3F_62C1, 6'b010_110);
        for (int i = 0; i < 6; i++)
            single_check($sformatf("thr%0d", i), {16'h0000, thr_v[i]}, {thr_c[i], 3'b001});

        // All 64 constellation points, streamed under random backpressure
        k = 0; guard = 0;
        while (k < 64 && guard < 2000) begin
            tick();
            pt = tx_point(6'(k));
            CYC_I = 1'b1; WE_I = 1'b1; STB_I = 1'b1; DAT_I = pt;
            ACK_I = ($urandom_range(0, 3) != 0);
            #1;
            if (ACK_O) begin
                chk("tx_inv", {26'h0, ref_slice(pt[15:0]), ref_slice(pt[31:16])}, 32'(k));
                k++;
            end
            guard++;
        end
        chk("sweep_sent", 32'(k), 32'd64);
        drain();

        // Backpressure: 8 distinct symbols, ACK_I low for 3 cycles mid-stream
        for (int i = 0; i < 8; i++) bp_sym[i] = 6'((i * 7 + 3) % 64);
        sent = 0; d0 = n_del;
        for (int t = 0; t < 20; t++) begin
            tick();
            ACK_I = !(t >= 5 && t < 8);
            STB_I = (sent < 8);
            DAT_I = tx_point(bp_sym[(sent < 8) ? sent : 7]);
            #1;
            if (!ACK_I && STB_O) chk("halt_ack", {31'h0, ACK_O}, 32'h0);
            if (ACK_O) sent++;
        end
        chk("bp_sent", 32'(sent), 32'd8);
        drain();
        chk("bp_delivered", 32'(n_del - d0), 32'd8);

        // Randomized traffic with occasional resets
        for (int t = 0; t < 3000; t++) begin
            tick();
            RST_I = ($urandom_range(0, 299) == 0);
            CYC_I = ($urandom_range(0, 15) != 0);
            STB_I = ($urandom_range(0, 3) != 0);
            WE_I  = ($urandom_range(0, 15) != 0);
            ACK_I = ($urandom_range(0, 2) != 0);
            DAT_I = {rand_axis(), rand_axis()};
        end
        RST_I = 1'b0; CYC_I = 1'b1; WE_I = 1'b1;
        drain();

        // Reset while output and stage 1 are both full
        guard = 0;
        CYC_I = 1'b1; WE_I = 1'b1; STB_I = 1'b1; ACK_I = 1'b1;
        while (guard < 10) begin
            tick();
            DAT_I = tx_point(6'($urandom_range(0, 63)));
            if (STB_O) break;
            guard++;
        end
        chk("mid_stb_before", {31'h0, STB_O}, 32'h1);
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0; STB_I = 1'b0;
        chk("mid_rst_stb", {31'h0, STB_O}, 32'h0);
        chk("mid_rst_dat", {26'h0, DAT_O}, 32'h0);
        chk("mid_rst_cyc", {31'h0, CYC_O}, 32'h0);
        single_check("post_rst", 32'h13C0_8001, 6'b111_001);

`ifdef QAM64_DEMOD_CLIP_EN
        // Clip detection: three clipped samples, two clean ones
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        for (int i = 0; i < 5; i++)
            single_check($sformatf("clip%0d", i), (i < 3) ? 32'h0000_7F00 : 32'h0000_1000,
                         (i < 3) ? 6'b011_001 : 6'b001_001);
        tick();
        chk("clip_cnt_final", {16'h0, CLIP_CNT_O}, 32'd3);
`endif

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
